// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Register file with two combinational read ports, one write port with
// same-cycle write-to-read bypass, and a per-register scoreboard of pending
// (busy) bits. Pending bits are set by an issue request (BSET/BSA) and
// cleared by the write that delivers the result.
//
// Parameters
//   DW       data width of each register
//   AW       address width; the file holds 2**AW registers
//   ZERO_R0  1: R0 reads as zero and ignores writes and issue requests
//
// Ports
//   CLK               clock; all state changes on the rising edge
//   RSTN              asynchronous active-low reset
//   RSA, RTA          read addresses, ports S and T
//   RSR, RTR          read data, ports S and T (combinational, bypassed)
//   WE, WA, WD        write enable, address, data
//   BSET, BSA         mark register BSA pending
//   RS_BUSY, RT_BUSY  pending status of RSA / RTA (a same-cycle write hides it)
//   PEND_CNT          registered count of pending registers
//   DBL_SET           sticky flag: an already-pending register was re-issued
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [AW-1:0] RSA,
  input  logic [AW-1:0] RTA,
  output logic [DW-1:0] RSR,
  output logic [DW-1:0] RTR,
  input  logic          WE,
  input  logic [AW-1:0] WA,
  input  logic [DW-1:0] WD,
  input  logic          BSET,
  input  logic [AW-1:0] BSA,
  output logic          RS_BUSY,
  output logic          RT_BUSY,
  output logic [AW:0]   PEND_CNT,
  output logic          DBL_SET
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_pend_cnt;
  logic             r_dbl_set;

  logic             w_wr_ok;
  logic             w_bset_ok;
  logic             w_same_addr;
  logic             w_cnt_inc;
  logic             w_cnt_dec;
  logic             w_dbl_hit;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_rs_byp;
  logic             w_rt_byp;

  // Writes and issues aimed at a hard-wired R0 are dropped before they reach
  // any state, so R0 can never hold data or become pending.
  assign w_wr_ok     = WE   && !(ZERO_R0 && (WA  == '0));
  assign w_bset_ok   = BSET && !(ZERO_R0 && (BSA == '0));
  assign w_same_addr = w_wr_ok && w_bset_ok && (WA == BSA);

  // Count moves by one in each direction. An issue to a free register adds
  // one; a write retiring a pending register subtracts one unless the same
  // register is re-issued in that cycle (it stays pending).
  assign w_cnt_inc = w_bset_ok && !r_busy[BSA];
  assign w_cnt_dec = w_wr_ok && r_busy[WA] && !w_same_addr;

  // Re-issuing a register that is still pending is an error, except when the
  // write retiring it lands in the same cycle.
  assign w_dbl_hit = w_bset_ok && r_busy[BSA] && !w_same_addr;

  // NOTE: combinational blocks use blocking assignments and assign every
  // output a default first, so later lines see earlier ones and no latch is
  // inferred. The set is applied after the clear: a new issue wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)   w_busy_nxt[WA]  = 1'b0;
    if (w_bset_ok) w_busy_nxt[BSA] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only. The register
  // array is reset here on purpose: the reset value of every register is
  // architecturally visible, so it cannot be left to a RAM macro.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy     <= '0;
      r_pend_cnt <= '0;
      r_dbl_set  <= 1'b0;
    end else begin
      if (w_wr_ok) r_regs[WA] <= WD;
      r_busy <= w_busy_nxt;
      if (w_cnt_inc && !w_cnt_dec)      r_pend_cnt <= r_pend_cnt + CNT_ONE;
      else if (w_cnt_dec && !w_cnt_inc) r_pend_cnt <= r_pend_cnt - CNT_ONE;
      if (w_dbl_hit) r_dbl_set <= 1'b1;
    end
  end

  // Read ports. The array is already zero during reset; RSTN additionally
  // gates the bypass path so a write presented during reset is not visible.
  assign w_rs_byp = w_wr_ok && (WA == RSA);
  assign w_rt_byp = w_wr_ok && (WA == RTA);

  assign RSR = !RSTN                      ? '0 :
               w_rs_byp                   ? WD :
               (ZERO_R0 && (RSA == '0))   ? '0 : r_regs[RSA];
  assign RTR = !RSTN                      ? '0 :
               w_rt_byp                   ? WD :
               (ZERO_R0 && (RTA == '0))   ? '0 : r_regs[RTA];

  // A write in flight to the read address delivers the value this cycle, so
  // the consumer must not see the register as pending.
  assign RS_BUSY = RSTN && r_busy[RSA] && !w_rs_byp;
  assign RT_BUSY = RSTN && r_busy[RTA] && !w_rt_byp;

  assign PEND_CNT = r_pend_cnt;
  assign DBL_SET  = r_dbl_set;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Self-checking bench for reg_file_sb. A behavioural model predicts every
// output; predictions are pushed to a scoreboard queue when stimulus is
// driven and popped against the DUT when the output is sampled.
// Instance u_dut: defaults (DW=32, AW=5, ZERO_R0=1).
// Instance u_small: DW=8, AW=3, ZERO_R0=0.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance
  logic [4:0]  rsa, rta, wa, bsa;
  logic [31:0] rsr, rtr, wd;
  logic        we, bset, rs_busy, rt_busy, dbl_set;
  logic [5:0]  pend_cnt;

  // small instance
  logic [2:0]  b_rsa, b_rta, b_wa, b_bsa;
  logic [7:0]  b_rsr, b_rtr, b_wd;
  logic        b_we, b_bset, b_rs_busy, b_rt_busy, b_dbl_set;
  logic [3:0]  b_pend_cnt;

  reg_file_sb u_dut (
    .CLK(clk), .RSTN(rst_n), .RSA(rsa), .RTA(rta), .RSR(rsr), .RTR(rtr),
    .WE(we), .WA(wa), .WD(wd), .BSET(bset), .BSA(bsa),
    .RS_BUSY(rs_busy), .RT_BUSY(rt_busy), .PEND_CNT(pend_cnt), .DBL_SET(dbl_set)
  );

  reg_file_sb #(.DW(8), .AW(3), .ZERO_R0(1'b0)) u_small (
    .CLK(clk), .RSTN(rst_n), .RSA(b_rsa), .RTA(b_rta), .RSR(b_rsr), .RTR(b_rtr),
    .WE(b_we), .WA(b_wa), .WD(b_wd), .BSET(b_bset), .BSA(b_bsa),
    .RS_BUSY(b_rs_busy), .RT_BUSY(b_rt_busy), .PEND_CNT(b_pend_cnt), .DBL_SET(b_dbl_set)
  );

  // model of the main instance
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_dbl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, got, 32'hxxxx_xxxx);
    end else begin
      it = sb_q.pop_front();
      check(it.tag, got, it.exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] a, input logic wr_ok);
    if (wr_ok && wa == a) return wd;
    if (a == 5'd0) return 32'd0;
    return m_regs[a];
  endfunction

  function automatic logic m_bz(input logic [4:0] a, input logic wr_ok);
    return m_busy[a] && !(wr_ok && wa == a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_busy = 32'd0;
    m_dbl  = 1'b0;
  endtask

  task automatic drive(input logic i_we, input logic [4:0] i_wa, input logic [31:0] i_wd,
                       input logic i_bset, input logic [4:0] i_bsa,
                       input logic [4:0] i_rsa, input logic [4:0] i_rta);
    we = i_we; wa = i_wa; wd = i_wd; bset = i_bset; bsa = i_bsa; rsa = i_rsa; rta = i_rta;
  endtask

  // One clock of the main instance: entered just after a falling edge with
  // inputs already driven, leaves just after the next falling edge.
  task automatic cycle();
    logic wr_ok, bs_ok;
    wr_ok = we && (wa != 5'd0);
    bs_ok = bset && (bsa != 5'd0);
    push("rsr", m_rd(rsa, wr_ok));
    push("rtr", m_rd(rta, wr_ok));
    push("rs_busy", 32'(m_bz(rsa, wr_ok)));
    push("rt_busy", 32'(m_bz(rta, wr_ok)));
    #2;
    pop_check("rsr", rsr);
    pop_check("rtr", rtr);
    pop_check("rs_busy", 32'(rs_busy));
    pop_check("rt_busy", 32'(rt_busy));
    @(posedge clk);
    if (bs_ok && m_busy[bsa] && !(wr_ok && wa == bsa)) m_dbl = 1'b1;
    if (wr_ok) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (bs_ok) m_busy[bsa] = 1'b1;
    push("pend_cnt", 32'($countones(m_busy)));
    push("dbl_set", 32'(m_dbl));
    #1;
    pop_check("pend_cnt", 32'(pend_cnt));
    pop_check("dbl_set", 32'(dbl_set));
    @(negedge clk);
  endtask

  // One clock of the small instance with explicit expectations.
  task automatic b_cycle(input logic [7:0] e_rsr, input logic e_rs_busy,
                         input logic [3:0] e_pend, input logic e_dbl);
    push("b_rsr", 32'(e_rsr));
    push("b_rs_busy", 32'(e_rs_busy));
    #2;
    pop_check("b_rsr", 32'(b_rsr));
    pop_check("b_rs_busy", 32'(b_rs_busy));
    @(posedge clk);
    push("b_pend_cnt", 32'(e_pend));
    push("b_dbl_set", 32'(e_dbl));
    #1;
    pop_check("b_pend_cnt", 32'(b_pend_cnt));
    pop_check("b_dbl_set", 32'(b_dbl_set));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    b_we = 0; b_wa = 0; b_wd = 0; b_bset = 0; b_bsa = 0; b_rsa = 0; b_rta = 0;
    // reset asserted with a bypassable write presented: reads must stay zero
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'h1111_2222, 1'b1, 5'd3, 5'd3, 5'd3);
    #2;
    check("rst_rsr", rsr, 32'd0);
    check("rst_rs_busy", 32'(rs_busy), 32'd0);
    check("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    check("rst_dbl_set", 32'(dbl_set), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // write with same-cycle bypass, then plain read
    drive(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd3, 5'd3); cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);          cycle();
    check("r3_value", rsr, 32'hDEAD_BEEF);

    // R0 ignores writes and issues
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 5'd0, 5'd3); cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);          cycle();

    // issue R5, observe pending on T, retire with a write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0, 5'd5);          cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);          cycle();
    drive(1'b1, 5'd5, 32'h5555_0005, 1'b0, 5'd0, 5'd5, 5'd5);  cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);          cycle();

    // R7: re-issue with same-cycle retire is legal, bare re-issue is not
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);          cycle();
    drive(1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd7, 5'd7, 5'd7);  cycle();
    check("dbl_after_reissue_with_write", 32'(dbl_set), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);          cycle();
    check("dbl_after_bare_reissue", 32'(dbl_set), 32'd1);
    drive(1'b1, 5'd7, 32'h7777_0077, 1'b0, 5'd0, 5'd7, 5'd1);  cycle();

    // random traffic, including simultaneous issue/retire on different regs
    for (int n = 0; n < 200; n++) begin
      logic [4:0] ra;
      ra = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ra, ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31)));
      cycle();
    end

    // small instance: R0 is an ordinary register, count reaches full depth
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    b_we = 1'b1; b_wa = 3'd0; b_wd = 8'hA5; b_bset = 1'b1; b_bsa = 3'd0; b_rsa = 3'd0; b_rta = 3'd0;
    b_cycle(8'hA5, 1'b0, 4'd1, 1'b0);
    b_we = 1'b0; b_bset = 1'b0;
    b_cycle(8'hA5, 1'b1, 4'd1, 1'b0);
    for (int a = 1; a < 8; a++) begin
      b_bset = 1'b1; b_bsa = 3'(a);
      b_cycle(8'hA5, 1'b1, 4'(a + 1), 1'b0);
    end
    b_bset = 1'b1; b_bsa = 3'd3;
    b_cycle(8'hA5, 1'b1, 4'd8, 1'b1);
    b_bset = 1'b0;

    // fill the main scoreboard, then reset asynchronously mid-clock
    for (int a = 1; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(a), 5'd0);
      cycle();
    end
    check("pend_full", 32'(pend_cnt), 32'd31);
    @(posedge clk);
    #2;
    drive(1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd4, 5'd3, 5'd4);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_pend_cnt", 32'(pend_cnt), 32'd0);
    check("async_dbl_set", 32'(dbl_set), 32'd0);
    check("async_rsr_bypass", rsr, 32'd0);
    check("async_rt_busy", 32'(rt_busy), 32'd0);
    check("async_b_pend_cnt", 32'(b_pend_cnt), 32'd0);
    for (int a = 0; a < 32; a++) begin
      rsa = 5'(a);
      push("rst_reg", 32'd0);
      #1;
      pop_check("rst_reg", rsr);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // write presented during reset was discarded; first edge after works
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);          cycle();
    drive(1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd4, 5'd3, 5'd4);  cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd4);          cycle();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL provide parameter DW, default 32, data width of each register.
REQ-002 SHALL provide parameter AW, default 5, address width; depth = 2**AW registers.
REQ-003 SHALL provide parameter ZERO_R0, default 1, when 1 register 0 reads as zero and ignores writes and busy-sets.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports RSA, RTA  input  AW  read addresses, ports S and T.
REQ-007 SHALL have ports RSR, RTR  output  DW  read data, ports S and T.
REQ-008 SHALL have port WE  input  1  write enable; port WA  input  AW  write address; port WD  input  DW  write data.
REQ-009 SHALL have port BSET  input  1  mark register pending; port BSA  input  AW  address to mark.
REQ-010 SHALL have ports RS_BUSY, RT_BUSY  output  1  pending status of RSA/RTA.
REQ-011 SHALL have port PEND_CNT  output  AW+1  number of pending registers.
REQ-012 SHALL have port DBL_SET  output  1  sticky error flag.

Function
REQ-013 Write: on rising CLK with WE=1, R[WA] <= WD; suppressed when ZERO_R0=1 and WA=0.
REQ-014 Reads combinational; R0 returns 0 when ZERO_R0=1.
REQ-015 Bypass: if WE=1, WA=RSA and the write is not suppressed, RSR = WD same cycle; identical rule for RTA/RTR.
REQ-016 Scoreboard: one busy bit per register; BSET=1 sets busy[BSA] at the edge (ignored for BSA=0 when ZERO_R0=1).
REQ-017 Any non-suppressed write (WE=1) clears busy[WA] at the edge.
REQ-018 Same-cycle BSET and WE to same address: busy ends set (new issue wins); data still written.
REQ-019 RS_BUSY = busy[RSA] AND NOT (WE=1 and WA=RSA, not suppressed); same for RT_BUSY; R0 never busy when ZERO_R0=1.
REQ-020 PEND_CNT registered, equals population of busy bits after each edge; +1, -1, or unchanged per cycle; never exceeds 2**AW, never wraps below 0.
REQ-021 DBL_SET set at edge when BSET=1 to an address already busy and not cleared by a same-cycle write; remains 1 until reset.
REQ-022 WE to a non-busy register SHALL write normally and leave PEND_CNT unchanged.
REQ-023 RS/RT ports independent; RSA=RTA yields identical data and busy.

Reset
REQ-024 RSTN=0 SHALL immediately, regardless of CLK, clear all registers to 0, all busy bits, PEND_CNT=0, DBL_SET=0.
REQ-025 Reset mid-operation discards in-flight write/BSET of that cycle; first rising edge with RSTN=1 behaves normally.
REQ-026 Reads during reset SHALL return 0 and busy 0.

Verification
REQ-027 Reset, WE=1 WA=3 WD=0xDEADBEEF, RSA=3 same cycle -> RSR=0xDEADBEEF (bypass); next cycle WE=0 -> RSR=0xDEADBEEF.
REQ-028 ZERO_R0=1: WE=1 WA=0 WD=0x12345678, BSET BSA=0 -> RSR(RSA=0)=0, RS_BUSY=0, PEND_CNT=0.
REQ-029 BSET BSA=5 -> RT_BUSY(RTA=5)=1, PEND_CNT=1; later WE WA=5 -> RT_BUSY=0 that cycle, PEND_CNT=0 next.
REQ-030 BSET BSA=7 and WE WA=7 same cycle with 7 already busy -> busy stays 1, PEND_CNT unchanged, DBL_SET stays 0; BSET BSA=7 alone next -> DBL_SET=1.
REQ-031 Set busy on all 31 nonzero registers -> PEND_CNT=31; assert RSTN=0 mid-clock -> PEND_CNT=0, all registers 0, DBL_SET=0 without clock edge.
REQ-032 Sweep DW=8, AW=3, ZERO_R0=0: write 0xA5 to R0, BSET R0 -> RSR=0xA5, RS_BUSY=1, PEND_CNT=1.
